// File: rtl/atm_pkg.sv
// atm_pkg: shared op/status codes, FSM states and constants for the ATM bank responder
package atm_pkg;
  typedef logic [31:0] amount_t;
  typedef enum logic [2:0] {
    OP_LOGOUT   = 3'd0,
    OP_BALANCE  = 3'd1,
    OP_WITHDRAW = 3'd2,
    OP_DEPOSIT  = 3'd3,
    OP_TRANSFER = 3'd4,
    OP_VERIFY   = 3'd5
  } op_e;
  typedef enum logic [3:0] {
    ST_OK        = 4'd0,
    ST_BAD_PIN   = 4'd1,
    ST_LOCKED    = 4'd2,
    ST_INSUFF    = 4'd3,
    ST_BAD_ACCT  = 4'd4,
    ST_NOT_AUTH  = 4'd5,
    ST_BAD_OP    = 4'd6,
    ST_OVERFLOW  = 4'd7,
    ST_LIMIT     = 4'd8
  } status_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
  localparam logic [3:0]  ATM_PIN          = 4'hE;
  localparam logic [15:0] ATM_PAYEE_ACCT   = 16'hD903;
  localparam amount_t     ATM_INIT_BALANCE = 32'h000186A0;
  localparam int          ATM_MAX_TRIES    = 3;
endpackage

// File: rtl/atm_pin_guard.sv
// atm_pin_guard: PIN compare, wrong-PIN try counter, sticky lockout and session authentication
module atm_pin_guard
  import atm_pkg::*;
#(
  parameter logic [3:0] PIN = ATM_PIN,
  parameter int MAX_TRIES = ATM_MAX_TRIES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       eval,
  input  logic [2:0] op,
  input  logic [3:0] pin,
  output logic       pin_ok,
  output logic       lock_now,
  output logic       locked,
  output logic       authenticated
);
  localparam logic [1:0] LAST_TRY = 2'(MAX_TRIES - 1);
  logic [1:0] tries;
  assign pin_ok = pin == PIN;
  assign lock_now = !locked && op == OP_VERIFY && !pin_ok && tries == LAST_TRY;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tries <= '0;
      locked <= 1'b0;
      authenticated <= 1'b0;
    end else if (eval && !locked) begin
      if (op == OP_LOGOUT) authenticated <= 1'b0;
      else if (op == OP_VERIFY) begin
        authenticated <= pin_ok || (authenticated && !lock_now);
        tries <= pin_ok ? 2'd0 : tries + 2'd1;
        locked <= lock_now;
      end
    end
  end
endmodule

// File: rtl/atm_bank_responder.sv
// atm_bank_responder: bank-side account host; optional per-session debit cap under ATM_DAILY_LIMIT_EN
module atm_bank_responder
  import atm_pkg::*;
#(
  parameter logic [3:0]  PIN          = ATM_PIN,
  parameter logic [15:0] PAYEE_ACCT   = ATM_PAYEE_ACCT,
  parameter amount_t     INIT_BALANCE = ATM_INIT_BALANCE,
  parameter int          MAX_TRIES    = ATM_MAX_TRIES
`ifdef ATM_DAILY_LIMIT_EN
  , parameter amount_t   DAILY_LIMIT  = 32'd20000
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [3:0]  req_pin,
  input  logic [15:0] req_acct,
  input  logic [31:0] req_amount,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_status,
  output logic [31:0] rsp_balance,
  output logic        locked
);
  state_e state, state_nxt;
  logic [2:0] op;
  logic [3:0] pin;
  logic [15:0] acct;
  amount_t amt, balance, bal_nxt;
  status_e st;
  logic pin_ok, lock_now, auth, over_limit;
  logic [32:0] sum;
  assign req_ready = state == S_IDLE;
  assign rsp_valid = state == S_RESP;
  assign sum = {1'b0, balance} + {1'b0, amt};
  atm_pin_guard #(.PIN(PIN), .MAX_TRIES(MAX_TRIES)) u_guard (
    .clk(clk),
    .reset_n(reset_n),
    .eval(state == S_EXEC),
    .op(op),
    .pin(pin),
    .pin_ok(pin_ok),
    .lock_now(lock_now),
    .locked(locked),
    .authenticated(auth)
  );
`ifdef ATM_DAILY_LIMIT_EN
  amount_t debit;
  logic [32:0] dsum;
  assign dsum = {1'b0, debit} + {1'b0, amt};
  assign over_limit = dsum > {1'b0, DAILY_LIMIT};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) debit <= '0;
    else if (state == S_EXEC)
      debit <= (op == OP_LOGOUT || lock_now) ? '0 :
               (st == ST_OK && (op == OP_WITHDRAW || op == OP_TRANSFER)) ? dsum[31:0] : debit;
  end
`else
  assign over_limit = 1'b0;
`endif
  always_comb begin
    state_nxt = state == S_IDLE ? (req_valid ? S_EXEC : S_IDLE) :
                state == S_EXEC ? S_RESP : (rsp_ready ? S_IDLE : S_RESP);
  end
  // Status precedence: lockout, bad op, session ops, auth gate, then the money checks
  always_comb begin
    st = ST_OK;
    bal_nxt = balance;
    if (locked) st = ST_LOCKED;
    else if (op > OP_VERIFY) st = ST_BAD_OP;
    else if (op == OP_VERIFY) st = pin_ok ? ST_OK : lock_now ? ST_LOCKED : ST_BAD_PIN;
    else if (op != OP_LOGOUT) begin
      if (!auth) st = ST_NOT_AUTH;
      else if (op == OP_DEPOSIT) begin
        st = sum[32] ? ST_OVERFLOW : ST_OK;
        bal_nxt = sum[32] ? balance : sum[31:0];
      end else if (op == OP_WITHDRAW || op == OP_TRANSFER) begin
        if (op == OP_TRANSFER && acct != PAYEE_ACCT) st = ST_BAD_ACCT;
        else if (amt > balance) st = ST_INSUFF;
        else if (over_limit) st = ST_LIMIT;
        else bal_nxt = balance - amt;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      op <= '0;
      pin <= '0;
      acct <= '0;
      amt <= '0;
      balance <= INIT_BALANCE;
      rsp_status <= '0;
      rsp_balance <= INIT_BALANCE;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        op <= req_op;
        pin <= req_pin;
        acct <= req_acct;
        amt <= req_amount;
      end
      if (state == S_EXEC) begin
        balance <= bal_nxt;
        rsp_status <= st;
        rsp_balance <= bal_nxt;
      end
    end
  end
endmodule

// File: tb/tb_atm_bank_responder.sv
// tb_atm_bank_responder: directed requests with a queued scoreboard checked by a response monitor
module tb_atm_bank_responder;
  localparam logic [3:0] OK = 0, BAD_PIN = 1, LOCKED = 2, INSUFF = 3, BAD_ACCT = 4,
                         NOT_AUTH = 5, BAD_OP = 6, OVF = 7, LIMIT = 8;
  localparam logic [2:0] LOGOUT = 0, BAL = 1, WDR = 2, DEP = 3, XFER = 4, VER = 5;
  logic clk = 0, reset_n, req_valid, req_ready, rsp_valid, rsp_ready, locked;
  logic [2:0] req_op;
  logic [3:0] req_pin, rsp_status;
  logic [15:0] req_acct;
  logic [31:0] req_amount, rsp_balance;
  logic [35:0] exp_q[$];
  logic [35:0] e;
  int checks = 0, failures = 0, nrsp = 0;
  atm_bank_responder dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_pin(req_pin), .req_acct(req_acct), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      nrsp++;
      if (exp_q.size() == 0) chk("unexpected_rsp", {rsp_status, rsp_balance}, 36'h0);
      else begin
        e = exp_q.pop_front();
        chk($sformatf("rsp%0d", nrsp), {rsp_status, rsp_balance}, e);
      end
    end
  end
  task automatic issue(input logic [2:0] op, input logic [3:0] pin, input logic [15:0] acct,
                       input logic [31:0] amt, input logic [3:0] st, input logic [31:0] bal);
    exp_q.push_back({st, bal});
    req_op = op; req_pin = pin; req_acct = acct; req_amount = amt; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk) chk("lat_exec", 36'(rsp_valid), 36'd0);
    @(negedge clk) chk("lat_resp", 36'(rsp_valid), 36'd1);
  endtask
  task automatic done();
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("ready_timeout", 36'(req_ready), 36'd1);
  endtask
  task automatic txn(input logic [2:0] op, input logic [3:0] pin, input logic [15:0] acct,
                     input logic [31:0] amt, input logic [3:0] st, input logic [31:0] bal);
    issue(op, pin, acct, amt, st, bal);
    done();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 0; rsp_ready = 1; req_valid = 0; req_op = 0; req_pin = 0; req_acct = 0; req_amount = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("rst_ready", 36'(req_ready), 36'd1);
    chk("rst_valid", 36'(rsp_valid), 36'd0);
    chk("rst_rsp", {rsp_status, rsp_balance}, {OK, 32'd100000});
    chk("rst_locked", 36'(locked), 36'd0);
    txn(BAL, 0, 0, 0, NOT_AUTH, 100000);
    txn(VER, 4'hE, 0, 0, OK, 100000);
    txn(BAL, 0, 0, 0, OK, 100000);
    txn(XFER, 0, 16'h1234, 500, BAD_ACCT, 100000);
    txn(XFER, 0, 16'hD903, 500, OK, 99500);
    txn(DEP, 0, 0, 500, OK, 100000);
    txn(WDR, 0, 0, 100001, INSUFF, 100000);
    txn(WDR, 0, 0, 0, OK, 100000);
`ifdef ATM_DAILY_LIMIT_EN
    txn(WDR, 0, 0, 15000, OK, 85000);
    txn(WDR, 0, 0, 6000, LIMIT, 85000);
    txn(LOGOUT, 0, 0, 0, OK, 85000);
    txn(VER, 4'hE, 0, 0, OK, 85000);
    txn(WDR, 0, 0, 6000, OK, 79000);
    txn(DEP, 0, 0, 21000, OK, 100000);
`else
    txn(WDR, 0, 0, 100000, OK, 0);
    txn(DEP, 0, 0, 1, OK, 1);
    txn(DEP, 0, 0, 32'hFFFFFFFF, OVF, 1);
    txn(DEP, 0, 0, 32'hFFFFFFFE, OK, 32'hFFFFFFFF);
    txn(WDR, 0, 0, 32'hFFFFFFFF, OK, 0);
    txn(DEP, 0, 0, 100000, OK, 100000);
`endif
    txn(3'd6, 0, 0, 0, BAD_OP, 100000);
    txn(3'd7, 0, 0, 0, BAD_OP, 100000);
    rsp_ready = 0;
    issue(DEP, 0, 0, 0, OK, 100000);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_op = DEP; req_amount = 7;
      @(negedge clk);
      chk("stall_rsp", {rsp_valid, rsp_status, rsp_balance[30:0]}, {1'b1, OK, 31'd100000});
      chk("stall_ready", 36'(req_ready), 36'd0);
    end
    req_valid = 0;
    rsp_ready = 1;
    done();
    txn(BAL, 0, 0, 0, OK, 100000);
    txn(LOGOUT, 0, 0, 0, OK, 100000);
    txn(BAL, 0, 0, 0, NOT_AUTH, 100000);
    txn(WDR, 0, 0, 5, NOT_AUTH, 100000);
    txn(VER, 4'h3, 0, 0, BAD_PIN, 100000);
    txn(VER, 4'hE, 0, 0, OK, 100000);
    txn(VER, 4'h3, 0, 0, BAD_PIN, 100000);
    txn(VER, 4'h3, 0, 0, BAD_PIN, 100000);
    txn(VER, 4'h3, 0, 0, LOCKED, 100000);
    chk("locked_set", 36'(locked), 36'd1);
    txn(VER, 4'hE, 0, 0, LOCKED, 100000);
    txn(LOGOUT, 0, 0, 0, LOCKED, 100000);
    txn(3'd7, 0, 0, 0, LOCKED, 100000);
    chk("locked_sticky", 36'(locked), 36'd1);
    reset_n = 0;
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    chk("locked_cleared", 36'(locked), 36'd0);
    txn(VER, 4'hE, 0, 0, OK, 100000);
    txn(DEP, 0, 0, 1000, OK, 101000);
    req_op = WDR; req_amount = 300; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    reset_n = 0;
    #1;
    chk("midrst_valid", 36'(rsp_valid), 36'd0);
    chk("midrst_bal", 36'(rsp_balance), 36'd100000);
    chk("midrst_ready", 36'(req_ready), 36'd1);
    @(negedge clk) reset_n = 1;
    @(negedge clk);
    txn(BAL, 0, 0, 0, NOT_AUTH, 100000);
    txn(VER, 4'hE, 0, 0, OK, 100000);
    txn(BAL, 0, 0, 0, OK, 100000);
    repeat (3) @(negedge clk);
    chk("queue_empty", 36'(exp_q.size()), 36'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
